// File: rtl/fft_reorder_pkg.sv
// fft_reorder_pkg: shared constants, lane-vector types and bit-reversal helper for the FFT reorder stage
package fft_reorder_pkg;
  localparam int DFLT_DW = 13;
  localparam int DFLT_LANES = 16;
  localparam int DFLT_N = 512;
  localparam int LOG2N = $clog2(DFLT_N);
  localparam int LOG2LANES = $clog2(DFLT_LANES);
  typedef logic signed [DFLT_DW-1:0] sample_t;
  typedef sample_t [DFLT_LANES-1:0] lane_vec_t;
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int nbits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (i < nbits) r = {r[30:0], value[i]};
    return r;
  endfunction
endpackage

// File: rtl/fft_reorder_bank.sv
// fft_reorder_bank: one frame of storage, lane-row write port and LANES independent read ports
module fft_reorder_bank
  import fft_reorder_pkg::*;
#(
  parameter int W = 26,
  parameter int LANES = 16,
  parameter int N = 512,
  localparam int FRAMES = N / LANES,
  localparam int CW = FRAMES > 1 ? $clog2(FRAMES) : 1,
  localparam int AW = $clog2(N)
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [CW-1:0]             wr_row,
  input  logic [LANES-1:0][W-1:0]   wr_data,
  input  logic [LANES-1:0][AW-1:0]  rd_pos,
  output logic [LANES-1:0][W-1:0]   rd_data
);
  logic [W-1:0] mem [N];
  always_ff @(posedge clk)
    if (we)
      for (int l = 0; l < LANES; l++)
        mem[AW'(32'(wr_row) * 32'(LANES) + 32'(l))] <= wr_data[l];
  for (genvar r = 0; r < LANES; r++) begin : g_rd
    assign rd_data[r] = mem[rd_pos[r]];
  end
endmodule

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong bit-reversed to natural-order frame reorder with ready/valid output
// Define FFT_REORDER_FFTSHIFT_EN to emit bins rotated by N/2 (DC in the middle beat).
module fft_bitrev_reorder
  import fft_reorder_pkg::*;
#(
  parameter int DW = 13,
  parameter int LANES = 16,
  parameter int N = 512
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  input  logic [LANES-1:0][DW-1:0] in_re,
  input  logic [LANES-1:0][DW-1:0] in_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES-1:0][DW-1:0] out_re,
  output logic [LANES-1:0][DW-1:0] out_im,
  output logic                     out_sof,
  output logic                     out_eof,
  output logic                     overflow,
  input  logic                     overflow_clr
);
  localparam int FRAMES = N / LANES;
  localparam int CW = FRAMES > 1 ? $clog2(FRAMES) : 1;
  localparam int AW = $clog2(N);
  localparam int W = 2 * DW;
`ifdef FFT_REORDER_FFTSHIFT_EN
  localparam int SHIFT = N / 2;
`else
  localparam int SHIFT = 0;
`endif
  logic [CW-1:0] wr_cyc, rd_cyc;
  logic [1:0] full, full_set, full_clr;
  logic wr_bank, rd_bank, dropping;
  logic wr_first, wr_last, drop_now, wr_en, wr_done, xfer, rd_last, rd_done;
  logic [LANES-1:0][W-1:0] wr_data, rd_data0, rd_data1, rd_data;
  logic [LANES-1:0][AW-1:0] rd_pos;
  assign wr_first = wr_cyc == '0;
  assign wr_last = wr_cyc == CW'(FRAMES - 1);
  // the drop decision is latched on the first beat and held for the rest of the frame
  assign drop_now = wr_first ? full[wr_bank] : dropping;
  assign wr_en = in_valid && !drop_now;
  assign wr_done = wr_en && wr_last;
  assign out_valid = full[rd_bank];
  assign xfer = out_valid && out_ready;
  assign rd_last = rd_cyc == CW'(FRAMES - 1);
  assign rd_done = xfer && rd_last;
  assign out_sof = out_valid && rd_cyc == '0;
  assign out_eof = out_valid && rd_last;
  assign full_set = {wr_done && wr_bank, wr_done && !wr_bank};
  assign full_clr = {rd_done && rd_bank, rd_done && !rd_bank};
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_cyc <= '0;
      wr_bank <= 1'b0;
      dropping <= 1'b0;
    end else if (in_valid) begin
      wr_cyc <= wr_last ? '0 : wr_cyc + 1'b1;
      if (wr_first) dropping <= full[wr_bank];
      if (wr_done) wr_bank <= !wr_bank;
    end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rd_cyc <= '0;
      rd_bank <= 1'b0;
    end else if (xfer) begin
      rd_cyc <= rd_last ? '0 : rd_cyc + 1'b1;
      if (rd_last) rd_bank <= !rd_bank;
    end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) full <= '0;
    else full <= (full & ~full_clr) | full_set;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) overflow <= 1'b0;
    else if (in_valid && wr_first && full[wr_bank]) overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign wr_data[l] = {in_re[l], in_im[l]};
    // natural bin k of this lane lives at position bitrev(k) of the bank
    assign rd_pos[l] = AW'(bitrev(32'(rd_cyc) * 32'(LANES) + 32'(l) + 32'(SHIFT), AW));
    assign out_re[l] = out_valid ? rd_data[l][W-1:DW] : '0;
    assign out_im[l] = out_valid ? rd_data[l][DW-1:0] : '0;
  end
  assign rd_data = rd_bank ? rd_data1 : rd_data0;
  fft_reorder_bank #(.W(W), .LANES(LANES), .N(N)) u_bank0 (
    .clk(clk), .we(wr_en && !wr_bank), .wr_row(wr_cyc), .wr_data(wr_data),
    .rd_pos(rd_pos), .rd_data(rd_data0)
  );
  fft_reorder_bank #(.W(W), .LANES(LANES), .N(N)) u_bank1 (
    .clk(clk), .we(wr_en && wr_bank), .wr_row(wr_cyc), .wr_data(wr_data),
    .rd_pos(rd_pos), .rd_data(rd_data1)
  );
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb_fft_bitrev_reorder: frame-level model bench for the bit-reversed reorder stage
module tb_fft_bitrev_reorder;
  import fft_reorder_pkg::*;
  localparam int DW = DFLT_DW;
  localparam int LANES = DFLT_LANES;
  localparam int N = DFLT_N;
  localparam int FRAMES = 1 << (LOG2N - LOG2LANES);
`ifdef FFT_REORDER_FFTSHIFT_EN
  localparam int SH = N / 2;
`else
  localparam int SH = 0;
`endif
  logic clk = 0, rstn = 0, in_valid = 0, out_ready = 0, overflow_clr = 0;
  logic out_valid, out_sof, out_eof, overflow;
  lane_vec_t in_re = '0, in_im = '0, out_re, out_im;
  always #5 clk = ~clk;
  fft_bitrev_reorder #(.DW(DW), .LANES(LANES), .N(N)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_sof(out_sof), .out_eof(out_eof), .overflow(overflow), .overflow_clr(overflow_clr)
  );
  int checks = 0, errors = 0;
  sample_t cur_re[N], cur_im[N], fre[2][N], fim[2][N];
  int head = 0, cnt = 0, wr_pos = 0, rd_beat = 0, xfers = 0;
  bit ov_m = 0, drop = 0, held = 0, lit_en = 0, lat_chk = 0;
  lane_vec_t hold_re, hold_im;
  function automatic int brev(int v, int n);
    int r = 0;
    for (int i = 0; i < n; i++) r = r * 2 + ((v >> i) & 1);
    return r;
  endfunction
  task automatic chk(string nm, longint got, longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", nm, got, exp);
    end
  endtask
  // frames are kept indexed by bin: position p of the input carries bin brev(p)
  task automatic mon();
    bit ev, set_ov;
    int k, slot;
    if (!rstn) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_overflow", overflow, 0);
      cnt = 0; head = 0; wr_pos = 0; rd_beat = 0; ov_m = 0; drop = 0; held = 0;
      return;
    end
    ev = cnt > 0;
    chk("out_valid", out_valid, ev);
    chk("overflow", overflow, ov_m);
    if (lat_chk) begin
      chk("latency_valid", out_valid, 1);
      lat_chk = 0;
    end
    if (held)
      for (int l = 0; l < LANES; l++) begin
        chk($sformatf("hold_re l%0d", l), out_re[l], hold_re[l]);
        chk($sformatf("hold_im l%0d", l), out_im[l], hold_im[l]);
      end
    if (ev) begin
      chk("sof", out_sof, rd_beat == 0);
      chk("eof", out_eof, rd_beat == FRAMES - 1);
      for (int l = 0; l < LANES; l++) begin
        k = (rd_beat * LANES + l + SH) % N;
        chk($sformatf("re b%0d l%0d", rd_beat, l), out_re[l], fre[head][k]);
        chk($sformatf("im b%0d l%0d", rd_beat, l), out_im[l], fim[head][k]);
      end
    end else chk("idle_zero", out_re == '0 && out_im == '0, 1);
    if (lit_en && ev) begin
`ifdef FFT_REORDER_FFTSHIFT_EN
      if (rd_beat == 0) chk("lit_b0l0_re", out_re[0], 1);
      if (rd_beat == 16) chk("lit_b16l0_re", out_re[0], 0);
`else
      if (rd_beat == 0) begin
        chk("lit_b0l1_re", out_re[1], 256);
        chk("lit_b0l1_im", out_im[1], -256);
        chk("lit_sof", out_sof, 1);
      end
      if (rd_beat == 1) chk("lit_b1l0_re", out_re[0], 16);
      if (rd_beat == 31) chk("lit_eof", out_eof, 1);
`endif
    end
    set_ov = 0;
    if (in_valid) begin
      if (wr_pos == 0) begin
        drop = cnt == 2;
        set_ov = drop;
      end
      if (!drop)
        for (int l = 0; l < LANES; l++) begin
          cur_re[brev(wr_pos * LANES + l, LOG2N)] = in_re[l];
          cur_im[brev(wr_pos * LANES + l, LOG2N)] = in_im[l];
        end
      wr_pos++;
    end
    if (set_ov) ov_m = 1;
    else if (overflow_clr) ov_m = 0;
    held = ev && !out_ready;
    hold_re = out_re;
    hold_im = out_im;
    if (ev && out_ready) begin
      xfers++;
      rd_beat++;
      if (rd_beat == FRAMES) begin
        rd_beat = 0;
        head = (head + 1) % 2;
        cnt--;
      end
    end
    if (wr_pos == FRAMES) begin
      wr_pos = 0;
      if (!drop) begin
        slot = (head + cnt) % 2;
        for (int i = 0; i < N; i++) begin
          fre[slot][i] = cur_re[i];
          fim[slot][i] = cur_im[i];
        end
        cnt++;
      end
    end
  endtask
  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask
  task automatic send_frame(int base, bit gap, int nb);
    for (int c = 0; c < nb; c++) begin
      in_valid = 1;
      for (int l = 0; l < LANES; l++) begin
        in_re[l] = DW'(base + c * LANES + l);
        in_im[l] = DW'(-(base + c * LANES + l));
      end
      tick();
      if (gap) begin
        in_valid = 0;
        tick();
      end
    end
    in_valid = 0;
  endtask
  task automatic drain(int budget);
    int n = 0;
    while (cnt > 0 && n < budget) begin
      tick();
      n++;
    end
    if (cnt > 0) chk("drain_timeout", cnt, 0);
  endtask
  initial begin
    int x0;
    tick();
    tick();
    rstn = 1;
    tick();
    out_ready = 1;
    lit_en = 1;
    x0 = xfers;
    send_frame(0, 0, FRAMES);
    lat_chk = 1;
    drain(100);
    lit_en = 0;
    chk("s1_xfers", xfers - x0, 32);
    out_ready = 0;
    x0 = xfers;
    send_frame(0, 0, FRAMES);
    out_ready = 1;
    repeat (5) tick();
    out_ready = 0;
    repeat (3) tick();
    out_ready = 1;
    drain(100);
    chk("s2_xfers", xfers - x0, 32);
    chk("s2_overflow", overflow, 0);
    out_ready = 0;
    x0 = xfers;
    send_frame(0, 0, FRAMES);
    send_frame(1000, 0, FRAMES);
    send_frame(2000, 0, FRAMES);
    chk("s3_overflow", overflow, 1);
    out_ready = 1;
    drain(200);
    chk("s3_xfers", xfers - x0, 64);
    tick();
    chk("s3_idle", out_valid, 0);
    overflow_clr = 1;
    tick();
    overflow_clr = 0;
    chk("s3_clr", overflow, 0);
    lit_en = 1;
    x0 = xfers;
    send_frame(0, 1, FRAMES);
    drain(100);
    lit_en = 0;
    chk("s4_xfers", xfers - x0, 32);
    out_ready = 0;
    send_frame(3000, 0, FRAMES);
    send_frame(100, 0, 10);
    rstn = 0;
    #1;
    chk("s5_async_valid", out_valid, 0);
    chk("s5_overflow", overflow, 0);
    tick();
    tick();
    rstn = 1;
    tick();
    out_ready = 1;
    lit_en = 1;
    x0 = xfers;
    send_frame(0, 0, FRAMES);
    drain(100);
    lit_en = 0;
    chk("s5_xfers", xfers - x0, 32);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
